// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU microsequencer: opcodes, control-line indices,
// one-hot ALU function codes and the sequencer state encoding.
package cpu_ctrl_pkg;

  localparam logic [7:0] OP_HALT  = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_MPY   = 8'h05;
  localparam logic [7:0] OP_DIV   = 8'h06;
  localparam logic [7:0] OP_AND   = 8'h07;
  localparam logic [7:0] OP_OR    = 8'h08;
  localparam logic [7:0] OP_NOT   = 8'h09;
  localparam logic [7:0] OP_SHL   = 8'h0A;
  localparam logic [7:0] OP_SHR   = 8'h0B;
  localparam logic [7:0] OP_JMP   = 8'h0C;
  localparam logic [7:0] OP_JGEZ  = 8'h0D;

  localparam int C0  = 0;
  localparam int C1  = 1;
  localparam int C2  = 2;
  localparam int C3  = 3;
  localparam int C4  = 4;
  localparam int C5  = 5;
  localparam int C6  = 6;
  localparam int C7  = 7;
  localparam int C8  = 8;
  localparam int C9  = 9;
  localparam int C10 = 10;
  localparam int C11 = 11;
  localparam int C12 = 12;
  localparam int C13 = 13;
  localparam int C14 = 14;
  localparam int C15 = 15;

  localparam logic [10:0] FN_ADD = 11'h002;
  localparam logic [10:0] FN_SUB = 11'h004;
  localparam logic [10:0] FN_MPY = 11'h008;
  localparam logic [10:0] FN_DIV = 11'h010;
  localparam logic [10:0] FN_AND = 11'h020;
  localparam logic [10:0] FN_OR  = 11'h040;
  localparam logic [10:0] FN_SHL = 11'h100;
  localparam logic [10:0] FN_SHR = 11'h200;
  localparam logic [10:0] FN_NOT = 11'h400;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_D    = 4'd4,
    S_E0   = 4'd5,
    S_E1   = 4'd6,
    S_E2   = 4'd7,
    S_E3   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  // Two-operand ALU instructions fetch a memory operand into BR before executing.
  function automatic logic is_binop(input logic [7:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational decode of (state, latched opcode, latched ACC sign) into the
// datapath control lines, one-hot ALU select and the illegal-opcode flag.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W   = 8,
  parameter int CTRL_W = 16,
  parameter int FN_W   = 11
) (
  input  state_t            state,
  input  logic [OP_W-1:0]   op_q,
  input  logic              sign_q,
  output logic [CTRL_W-1:0] ctrl,
  output logic [FN_W-1:0]   alu_fn,
  output logic              illegal_op
);

  function automatic logic [10:0] binop_fn(input logic [7:0] op);
    case (op)
      OP_ADD:  return FN_ADD;
      OP_SUB:  return FN_SUB;
      OP_MPY:  return FN_MPY;
      OP_DIV:  return FN_DIV;
      OP_AND:  return FN_AND;
      OP_OR:   return FN_OR;
      default: return 11'h000;
    endcase
  endfunction

  always_comb begin
    ctrl       = '0;
    alu_fn     = '0;
    illegal_op = 1'b0;
    case (state)
      S_F0: ctrl[C2] = 1'b1;
      S_F1: begin
        ctrl[C0]  = 1'b1;
        ctrl[C5]  = 1'b1;
        ctrl[C15] = 1'b1;
      end
      S_F2: ctrl[C4] = 1'b1;
      S_E0: begin
        case (op_q)
          OP_LOAD, OP_ADD, OP_SUB, OP_MPY, OP_DIV, OP_AND, OP_OR: ctrl[C8] = 1'b1;
          OP_STORE: begin
            ctrl[C8]  = 1'b1;
            ctrl[C11] = 1'b1;
          end
          OP_NOT, OP_SHL, OP_SHR: begin
            // Unary ops: y input forced to zero, result straight back into ACC.
            ctrl[C9]  = 1'b1;
            ctrl[C14] = 1'b1;
            alu_fn    = (op_q == OP_NOT) ? FN_NOT : ((op_q == OP_SHL) ? FN_SHL : FN_SHR);
          end
          OP_JMP:  ctrl[C3] = 1'b1;
          OP_JGEZ: ctrl[C3] = ~sign_q;
          default: illegal_op = 1'b1;
        endcase
      end
      S_E1: begin
        ctrl[C0] = 1'b1;
        if (op_q == OP_STORE) ctrl[C12] = 1'b1;
        else                  ctrl[C5]  = 1'b1;
      end
      S_E2: begin
        if (op_q == OP_LOAD) ctrl[C10] = 1'b1;
        else                 ctrl[C6]  = 1'b1;
      end
      S_E3: begin
        ctrl[C9] = 1'b1;
        alu_fn   = binop_fn(op_q);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Microsequencer top: fetch / decode / execute state register, latched opcode and
// ACC sign, retired-instruction counter and the busy/halted status flags.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W   = 8,
  parameter int CTRL_W = 16,
  parameter int FN_W   = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic              acc_sign,
  output logic [CTRL_W-1:0] ctrl,
  output logic [FN_W-1:0]   alu_fn,
  output logic              busy,
  output logic              halted,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  instr_cnt
);

  state_t          state;
  state_t          nxt;
  logic [OP_W-1:0] op_q;
  logic            sign_q;

  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE: nxt = start ? S_F0 : S_IDLE;
      S_F0:   nxt = S_F1;
      S_F1:   nxt = S_F2;
      S_F2:   nxt = S_D;
      // Illegal opcodes still pass through E0 so illegal_op has a cycle to pulse.
      S_D:    nxt = (opcode == OP_HALT) ? S_HALT : S_E0;
      S_E0:   nxt = (op_q == OP_LOAD || op_q == OP_STORE || is_binop(op_q)) ? S_E1 : S_F0;
      S_E1:   nxt = (op_q == OP_STORE) ? S_F0 : S_E2;
      S_E2:   nxt = (op_q == OP_LOAD) ? S_F0 : S_E3;
      S_E3:   nxt = S_F0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      sign_q    <= 1'b0;
      instr_cnt <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state  <= nxt;
      busy   <= (nxt != S_IDLE) && (nxt != S_HALT);
      halted <= (nxt == S_HALT);
      if (state == S_D) begin
        op_q      <= opcode;
        sign_q    <= acc_sign;
        instr_cnt <= instr_cnt + 1'b1;
      end
    end
  end

  cpu_ctrl_decode #(
    .OP_W   (OP_W),
    .CTRL_W (CTRL_W),
    .FN_W   (FN_W)
  ) u_decode (
    .state      (state),
    .op_q       (op_q),
    .sign_q     (sign_q),
    .ctrl       (ctrl),
    .alu_fn     (alu_fn),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  opcode;
  logic        acc_sign;
  logic [15:0] ctrl;
  logic [10:0] alu_fn;
  logic        busy;
  logic        halted;
  logic        illegal_op;
  logic [15:0] instr_cnt;

  logic [15:0] ctrl_w;
  logic [10:0] alu_fn_w;
  logic        busy_w;
  logic        halted_w;
  logic        illegal_op_w;
  logic [2:0]  instr_cnt_w;

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .opcode     (opcode),
    .acc_sign   (acc_sign),
    .ctrl       (ctrl),
    .alu_fn     (alu_fn),
    .busy       (busy),
    .halted     (halted),
    .illegal_op (illegal_op),
    .instr_cnt  (instr_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, so counter wrap is reachable quickly.
  cpu_control_unit #(.CNT_W(3)) dut_w (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .opcode     (opcode),
    .acc_sign   (acc_sign),
    .ctrl       (ctrl_w),
    .alu_fn     (alu_fn_w),
    .busy       (busy_w),
    .halted     (halted_w),
    .illegal_op (illegal_op_w),
    .instr_cnt  (instr_cnt_w)
  );

  typedef struct packed {
    logic [15:0] ctrl;
    logic [10:0] fn;
    logic        busy;
    logic        halted;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_no   = 0;
  logic [15:0] exp_cnt;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%04h expected 0x%04h", nm, cyc_no, act, req);
    end
  endtask

  always @(negedge clk) begin
    cyc_no++;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("ctrl",       ctrl,                   mon_e.ctrl);
      check("alu_fn",     {5'b0, alu_fn},         {5'b0, mon_e.fn});
      check("busy",       {15'b0, busy},          {15'b0, mon_e.busy});
      check("halted",     {15'b0, halted},        {15'b0, mon_e.halted});
      check("illegal_op", {15'b0, illegal_op},    {15'b0, mon_e.ill});
      check("instr_cnt",  instr_cnt,              mon_e.cnt);
      check("instr_cnt_w",{13'b0, instr_cnt_w},   {13'b0, mon_e.cnt[2:0]});
    end
  end

  task automatic cyc(input logic [15:0] c, input logic [10:0] f, input logic b,
                     input logic h, input logic il);
    exp_t e;
    e = '{c, f, b, h, il, exp_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [7:0] op, input logic s);
    cyc(16'h0004, 11'h000, 1'b1, 1'b0, 1'b0);
    cyc(16'h8021, 11'h000, 1'b1, 1'b0, 1'b0);
    cyc(16'h0010, 11'h000, 1'b1, 1'b0, 1'b0);
    opcode   = op;
    acc_sign = s;
    cyc(16'h0000, 11'h000, 1'b1, 1'b0, 1'b0);
    exp_cnt++;
    // Inputs change after D; outputs must follow the latched copies only.
    opcode   = 8'hA5;
    acc_sign = ~s;
  endtask

  task automatic instr(input logic [7:0] op, input logic s);
    logic [10:0] fn;
    fetch_decode(op, s);
    case (op)
      8'h01: begin
        cyc(16'h0100, 11'h000, 1'b1, 1'b0, 1'b0);
        cyc(16'h0021, 11'h000, 1'b1, 1'b0, 1'b0);
        cyc(16'h0400, 11'h000, 1'b1, 1'b0, 1'b0);
      end
      8'h02: begin
        cyc(16'h0900, 11'h000, 1'b1, 1'b0, 1'b0);
        cyc(16'h1001, 11'h000, 1'b1, 1'b0, 1'b0);
      end
      8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: begin
        case (op)
          8'h03:   fn = 11'h002;
          8'h04:   fn = 11'h004;
          8'h05:   fn = 11'h008;
          8'h06:   fn = 11'h010;
          8'h07:   fn = 11'h020;
          default: fn = 11'h040;
        endcase
        cyc(16'h0100, 11'h000, 1'b1, 1'b0, 1'b0);
        cyc(16'h0021, 11'h000, 1'b1, 1'b0, 1'b0);
        cyc(16'h0040, 11'h000, 1'b1, 1'b0, 1'b0);
        cyc(16'h0200, fn,      1'b1, 1'b0, 1'b0);
      end
      8'h09: cyc(16'h4200, 11'h400, 1'b1, 1'b0, 1'b0);
      8'h0A: cyc(16'h4200, 11'h100, 1'b1, 1'b0, 1'b0);
      8'h0B: cyc(16'h4200, 11'h200, 1'b1, 1'b0, 1'b0);
      8'h0C: cyc(16'h0008, 11'h000, 1'b1, 1'b0, 1'b0);
      8'h0D: cyc(s ? 16'h0000 : 16'h0008, 11'h000, 1'b1, 1'b0, 1'b0);
      8'h00: cyc(16'h0000, 11'h000, 1'b0, 1'b1, 1'b0);
      default: cyc(16'h0000, 11'h000, 1'b1, 1'b0, 1'b1);
    endcase
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    opcode   = 8'h00;
    acc_sign = 1'b0;
    exp_cnt  = 16'h0000;
    @(posedge clk);
    #1;
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    start = 1'b0;

    instr(8'h01, 1'b0);
    instr(8'h02, 1'b0);
    instr(8'h03, 1'b0);
    instr(8'h0A, 1'b0);
    instr(8'h0D, 1'b0);
    instr(8'h0D, 1'b1);
    instr(8'hFF, 1'b0);
    instr(8'h09, 1'b1);
    instr(8'h0B, 1'b0);
    instr(8'h04, 1'b0);
    instr(8'h05, 1'b1);
    instr(8'h06, 1'b0);
    instr(8'h07, 1'b0);
    instr(8'h08, 1'b0);
    start = 1'b1;
    instr(8'h0C, 1'b0);
    start = 1'b0;

    // Asynchronous reset in E1 of ADD: outputs must clear before any clock edge.
    fetch_decode(8'h03, 1'b0);
    cyc(16'h0100, 11'h000, 1'b1, 1'b0, 1'b0);
    rst     = 1'b0;
    exp_cnt = 16'h0000;
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cyc(16'h0000, 11'h000, 1'b0, 1'b0, 1'b0);
    start = 1'b0;

    instr(8'h01, 1'b0);
    instr(8'h00, 1'b0);
    start = 1'b1;
    cyc(16'h0000, 11'h000, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    cyc(16'h0000, 11'h000, 1'b0, 1'b1, 1'b0);
    cyc(16'h0000, 11'h000, 1'b0, 1'b1, 1'b0);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
